// File: rtl/hamming_rr_scheduler.sv
// Purpose: round-robin share of one serial XOR+popcount engine among NREQ requesters.
// Latency: accept to rsp_valid is W+1 cycles; accepts are at least W+2 cycles apart.
// Backpressure: rsp_ready low holds the result stable; no new request is accepted until the handshake.
module hamming_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ),
  parameter int CW   = $clog2(W+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_bits,
  output logic [CW-1:0]     rsp_count,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {IDLE, COUNT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [W-1:0]   diff;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  idx;
  logic [CW-1:0]  acc;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [W-1:0]   win_diff;

  // Round-robin pick: first valid at or above rr_ptr, else wrap to the lowest valid below it.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_diff  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i] && (i >= int'(rr_ptr))) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
        win_diff  = req_a[i*W +: W] ^ req_b[i*W +: W];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i] && (i < int'(rr_ptr))) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
        win_diff  = req_a[i*W +: W] ^ req_b[i*W +: W];
      end
    end
  end

  // Accept strobe is only offered while idle and out of reset, so it is one-hot or zero.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && win_found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Control FSM: latch the winner's operands, count one bit per cycle, then hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      diff      <= '0;
      shreg     <= '0;
      idx       <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bits  <= '0;
      rsp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            cur_id <= win_id;
            diff   <= win_diff;
            shreg  <= win_diff;
            idx    <= '0;
            acc    <= '0;
            state  <= COUNT;
          end
        end
        COUNT: begin
          // shreg[0] is diff[idx]; the final bit is folded straight into rsp_count.
          acc   <= acc + CW'(shreg[0]);
          shreg <= shreg >> 1;
          idx   <= idx + CW'(1);
          if (idx == CW'(W-1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_bits  <= diff;
            rsp_count <= acc + CW'(shreg[0]);
          end
        end
        RESP: begin
          // Pointer moves only on completion, to the requester after the one just served.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + IDW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hamming_rr_scheduler.md
Name: hamming_rr_scheduler

Overview:
Shares one bit-difference engine (XOR plus population count) among NREQ requesters under round-robin arbitration. The engine counts serially, one bit per cycle, which keeps the adder tree out of the shared path. Each request carries an operand pair. Each result is returned with the winning requester's ID, the difference mask and the difference count over a valid/ready response port. The block sits between several compare clients and a single response consumer.

Parameters:
NREQ, 4, number of requesters (>=2)
W, 8, operand width in bits
IDW, $clog2(NREQ), width of requester ID
CW, $clog2(W+1), width of difference count (4 for W=8)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  NREQ  per-requester request valid
req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W]
req_b  in  NREQ*W  operand B; same packing as req_a
req_ready  out  NREQ  one-hot accept strobe; at most one bit set
rsp_valid  out  1  result valid
rsp_id  out  IDW  index of the requester served
rsp_bits  out  W  req_a ^ req_b of the served request
rsp_count  out  CW  number of set bits in rsp_bits
rsp_ready  in  1  consumer accepts result

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0
  - rsp_valid=0, rsp_id=0, rsp_bits=0, rsp_count=0
  - req_ready=0, internal bit index and accumulator cleared
- FSM states: IDLE, COUNT, RESP.
- IDLE:
  - Winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 combinationally in the same cycle. This is the accept cycle T.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
  - At T's edge, latch: winner ID, diff=req_a[w]^req_b[w], idx=0, acc=0. Go to COUNT.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- COUNT:
  - Each cycle: acc += diff[idx], idx += 1.
  - After the cycle that processes idx=W-1, go to RESP. COUNT lasts exactly W cycles (T+1..T+W).
  - req_ready=0 throughout. rsp_ready is ignored.
- RESP:
  - rsp_valid=1 from cycle T+W+1. rsp_id, rsp_bits=diff and rsp_count=acc are registered and held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid && rsp_ready at an edge: rsp_valid drops to 0 next cycle, rr_ptr=(served ID+1) mod NREQ, go to IDLE.
  - rsp_bits and rsp_count keep their last values after the handshake. Only rsp_valid qualifies them.
- Latency and throughput:
  - Accept to rsp_valid is W+1 cycles.
  - Minimum spacing between accepts is W+2 cycles (W+2=10 for W=8), with rsp_ready held high.
- Arithmetic: acc is CW bits wide. The maximum value W always fits, so no saturation is needed.
- Boundary conditions:
  - a==b gives rsp_bits=0, rsp_count=0.
  - a==~b gives rsp_bits=all ones, rsp_count=W.
  - A requester that drops req_valid before being granted is simply skipped; nothing is latched.
  - Operand changes after the accept cycle have no effect on the result in flight.
  - rr_ptr advances only on response completion, never on accept.
  - Reset asserted in COUNT or RESP abandons the operation. No response is emitted, and all reset values apply on the next cycle.
  - rsp_ready asserted while rsp_valid=0 is ignored.
- Fairness: with all requesters continuously valid, each is served once per NREQ responses.

Test Plan:
1. Reset, then req_valid=4'b0001, a0=8'hA5, b0=8'h5A. Required: req_ready=4'b0001 at T; rsp_valid at T+9; rsp_id=0, rsp_bits=8'hFF, rsp_count=8.
2. All four valid from reset with distinct operands, rsp_ready=1. Required: grants in order 0,1,2,3, then 0; accepts 10 cycles apart; each rsp_count matches the reference popcount.
3. Pointer rotation. Serve requester 2, then raise req_valid=4'b1010. Required: requester 3 is granted first, then 1.
4. Backpressure. Hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid, rsp_id, rsp_bits and rsp_count stay constant, req_ready stays 0, and no new accept occurs until after the handshake.
5. Boundaries. a=b=8'h3C gives rsp_bits=0, count 0. a=8'h00, b=8'h80 gives rsp_bits=8'h80, count 1 (tests the last serial bit).
6. Assert rst_n=0 at cycle T+4 mid-COUNT. Required: the next cycle shows rsp_valid=0, rr_ptr=0, and no response for the abandoned request. A new request is served normally.
